// File: rtl/bcd_updown_counter_n.sv
// rtl/bcd_updown_counter_n.sv - Parametrised multi-digit BCD up/down counter with load, terminal count and wrap pulse
//
// Purpose:
//   A cascade of DIGITS BCD decades that counts up or down, supports a
//   synchronous parallel load and flags terminal count and wrap-around.
//   Optional macro BCD_COUNTER_SATURATE_EN: when defined, the counter holds
//   at all-9s (up) or all-0s (down) instead of wrapping, and wrapped stays 0.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   enable     in   count enable; Q holds when low
//   reverse    in   0 = count up, 1 = count down
//   load_en    in   synchronous parallel load strobe
//   load_value in   packed BCD load value, digit 0 in [3:0]
//   Q          out  packed BCD count, digit 0 in [3:0]
//   tc         out  combinational terminal count
//   wrapped    out  registered one-cycle pulse following a wrap edge
module bcd_updown_counter_n #(
    parameter int                    DIGITS      = 2,
    parameter logic [4*DIGITS-1:0]   RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  reverse,
    input  logic                  load_en,
    input  logic [4*DIGITS-1:0]   load_value,
    output logic [4*DIGITS-1:0]   Q,
    output logic                  tc,
    output logic                  wrapped
);

    logic [4*DIGITS-1:0] r_q;
    logic                r_wrapped;
    logic [4*DIGITS-1:0] w_up_next;
    logic [4*DIGITS-1:0] w_down_next;
    logic [4*DIGITS-1:0] w_load_clamped;
    // w_all9_below[k]: digits 0..k-1 are all 9 (carry into digit k).
    // w_all0_below[k]: digits 0..k-1 are all 0 (borrow into digit k).
    // Index DIGITS therefore means the whole count is at its limit.
    logic [DIGITS:0]     w_all9_below;
    logic [DIGITS:0]     w_all0_below;
    logic                w_at_limit;

    always_comb begin
        w_up_next       = r_q;
        w_down_next     = r_q;
        w_load_clamped  = load_value;
        w_all9_below    = '0;
        w_all0_below    = '0;
        w_all9_below[0] = 1'b1;
        w_all0_below[0] = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            w_all9_below[k+1] = w_all9_below[k] & (r_q[4*k +: 4] == 4'd9);
            w_all0_below[k+1] = w_all0_below[k] & (r_q[4*k +: 4] == 4'd0);

            if (w_all9_below[k]) begin
                w_up_next[4*k +: 4] = (r_q[4*k +: 4] >= 4'd9) ? 4'd0 : r_q[4*k +: 4] + 4'd1;
            end
            if (w_all0_below[k]) begin
                w_down_next[4*k +: 4] = (r_q[4*k +: 4] == 4'd0) ? 4'd9 : r_q[4*k +: 4] - 4'd1;
            end

            if (load_value[4*k +: 4] > 4'd9) begin
                w_load_clamped[4*k +: 4] = 4'd9;
            end
        end
    end

    assign w_at_limit = reverse ? w_all0_below[DIGITS] : w_all9_below[DIGITS];
    assign tc         = enable & w_at_limit;
    assign Q          = r_q;
    assign wrapped    = r_wrapped;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q       <= RESET_VALUE;
            r_wrapped <= 1'b0;
        end else if (load_en) begin
            r_q       <= w_load_clamped;
            r_wrapped <= 1'b0;
        end else if (enable) begin
`ifdef BCD_COUNTER_SATURATE_EN
            // At the limit the count simply holds; no wrap is ever flagged.
            if (!w_at_limit) begin
                r_q <= reverse ? w_down_next : w_up_next;
            end
            r_wrapped <= 1'b0;
`else
            r_q       <= reverse ? w_down_next : w_up_next;
            r_wrapped <= w_at_limit;
`endif
        end else begin
            r_wrapped <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bcd_updown_counter_n.sv
// tb/tb_bcd_updown_counter_n.sv - Directed self-checking bench for bcd_updown_counter_n
module tb_bcd_updown_counter_n;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       reverse;
    logic       load_en;
    logic [7:0] load_value;
    logic [7:0] Q;
    logic       tc;
    logic       wrapped;

    int passed;
    int total;

    bcd_updown_counter_n #(
        .DIGITS      (2),
        .RESET_VALUE (8'h00)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .reverse    (reverse),
        .load_en    (load_en),
        .load_value (load_value),
        .Q          (Q),
        .tc         (tc),
        .wrapped    (wrapped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] v);
        load_en    = 1'b1;
        load_value = v;
        tick();
        load_en    = 1'b0;
    endtask

    task automatic test_reset();
        // state while reset held from time zero
        total++;
        if (Q !== 8'h00) $display("FAIL reset_q: got %h expected 00", Q);
        else passed++;
        total++;
        if (wrapped !== 1'b0) $display("FAIL reset_wrapped: got %b expected 0", wrapped);
        else passed++;
        reset = 1'b0;
        do_load(8'h37);
        total++;
        if (Q !== 8'h37) $display("FAIL load_37: got %h expected 37", Q);
        else passed++;
        // async reset mid-count, checked before any further clock edge
        enable = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (Q !== 8'h00) $display("FAIL async_reset_q: got %h expected 00", Q);
        else passed++;
        total++;
        if (wrapped !== 1'b0) $display("FAIL async_reset_wrapped: got %b expected 0", wrapped);
        else passed++;
        reset  = 1'b0;
        enable = 1'b0;
    endtask

    task automatic test_up_carry();
        do_load(8'h09);
        enable  = 1'b1;
        reverse = 1'b0;
        tick();
        total++;
        if (Q !== 8'h10) $display("FAIL up_carry_09: got %h expected 10", Q);
        else passed++;
        enable = 1'b0;
        do_load(8'h98);
        enable = 1'b1;
        tick();
        total++;
        if (Q !== 8'h99) $display("FAIL up_to_99: got %h expected 99", Q);
        else passed++;
        total++;
        if (tc !== 1'b1) $display("FAIL up_tc_at_99: got %b expected 1", tc);
        else passed++;
        tick();
`ifdef BCD_COUNTER_SATURATE_EN
        total++;
        if (Q !== 8'h99) $display("FAIL up_sat_hold: got %h expected 99", Q);
        else passed++;
        total++;
        if (wrapped !== 1'b0) $display("FAIL up_sat_wrapped: got %b expected 0", wrapped);
        else passed++;
`else
        total++;
        if (Q !== 8'h00) $display("FAIL up_wrap_q: got %h expected 00", Q);
        else passed++;
        total++;
        if (wrapped !== 1'b1) $display("FAIL up_wrap_pulse: got %b expected 1", wrapped);
        else passed++;
        tick();
        total++;
        if (Q !== 8'h01) $display("FAIL up_after_wrap_q: got %h expected 01", Q);
        else passed++;
        total++;
        if (wrapped !== 1'b0) $display("FAIL up_wrap_one_cycle: got %b expected 0", wrapped);
        else passed++;
`endif
        enable = 1'b0;
    endtask

    task automatic test_down_borrow();
        do_load(8'h10);
        enable  = 1'b1;
        reverse = 1'b1;
        tick();
        total++;
        if (Q !== 8'h09) $display("FAIL down_borrow_10: got %h expected 09", Q);
        else passed++;
        enable = 1'b0;
        do_load(8'h00);
        enable = 1'b1;
        #1;
        total++;
        if (tc !== 1'b1) $display("FAIL down_tc_at_00: got %b expected 1", tc);
        else passed++;
        tick();
`ifdef BCD_COUNTER_SATURATE_EN
        total++;
        if (Q !== 8'h00) $display("FAIL down_sat_hold: got %h expected 00", Q);
        else passed++;
        total++;
        if (wrapped !== 1'b0) $display("FAIL down_sat_wrapped: got %b expected 0", wrapped);
        else passed++;
`else
        total++;
        if (Q !== 8'h99) $display("FAIL down_wrap_q: got %h expected 99", Q);
        else passed++;
        total++;
        if (wrapped !== 1'b1) $display("FAIL down_wrap_pulse: got %b expected 1", wrapped);
        else passed++;
`endif
        enable  = 1'b0;
        reverse = 1'b0;
    endtask

    task automatic test_load_priority();
        enable = 1'b1;
        do_load(8'hC5);
        total++;
        if (Q !== 8'h95) $display("FAIL load_clamp_c5: got %h expected 95", Q);
        else passed++;
        total++;
        if (wrapped !== 1'b0) $display("FAIL load_wrapped: got %b expected 0", wrapped);
        else passed++;
        do_load(8'hAF);
        total++;
        if (Q !== 8'h99) $display("FAIL load_clamp_af: got %h expected 99", Q);
        else passed++;
        do_load(8'h95);
        enable = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        total++;
        if (Q !== 8'h95) $display("FAIL hold_disabled: got %h expected 95", Q);
        else passed++;
        total++;
        if (tc !== 1'b0) $display("FAIL hold_tc: got %b expected 0", tc);
        else passed++;
        // tc must stay low when disabled even at the limit
        do_load(8'h99);
        #1;
        total++;
        if (tc !== 1'b0) $display("FAIL tc_disabled_at_99: got %b expected 0", tc);
        else passed++;
    endtask

    task automatic test_direction();
        int pulses;
        do_load(8'h42);
        enable  = 1'b1;
        reverse = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        total++;
        if (Q !== 8'h45) $display("FAIL dir_up3: got %h expected 45", Q);
        else passed++;
        reverse = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        total++;
        if (Q !== 8'h42) $display("FAIL dir_down3: got %h expected 42", Q);
        else passed++;
`ifndef BCD_COUNTER_SATURATE_EN
        reverse = 1'b0;
        pulses  = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (wrapped === 1'b1) pulses++;
        end
        total++;
        if (Q !== 8'h42) $display("FAIL full_run_q: got %h expected 42", Q);
        else passed++;
        total++;
        if (pulses != 1) $display("FAIL full_run_pulses: got %0d expected 1", pulses);
        else passed++;
`endif
        enable  = 1'b0;
        reverse = 1'b0;
    endtask

`ifdef BCD_COUNTER_SATURATE_EN
    task automatic test_saturate();
        int seen;
        do_load(8'h98);
        enable  = 1'b1;
        reverse = 1'b0;
        seen    = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (wrapped === 1'b1) seen++;
        end
        total++;
        if (Q !== 8'h99) $display("FAIL sat_up_q: got %h expected 99", Q);
        else passed++;
        total++;
        if (seen != 0) $display("FAIL sat_up_wrapped: got %0d pulses expected 0", seen);
        else passed++;
        total++;
        if (tc !== 1'b1) $display("FAIL sat_up_tc: got %b expected 1", tc);
        else passed++;
        enable = 1'b0;
        do_load(8'h01);
        enable  = 1'b1;
        reverse = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        total++;
        if (Q !== 8'h00) $display("FAIL sat_down_q: got %h expected 00", Q);
        else passed++;
        total++;
        if (tc !== 1'b1) $display("FAIL sat_down_tc: got %b expected 1", tc);
        else passed++;
        enable  = 1'b0;
        reverse = 1'b0;
    endtask
`endif

    initial begin
        passed     = 0;
        total      = 0;
        reset      = 1'b1;
        enable     = 1'b0;
        reverse    = 1'b0;
        load_en    = 1'b0;
        load_value = 8'h00;
        tick();
        tick();
        test_reset();
        test_up_carry();
        test_down_borrow();
        test_load_priority();
        test_direction();
`ifdef BCD_COUNTER_SATURATE_EN
        test_saturate();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
